// File: rtl/rfphoenix_pma_loader_pkg.sv
// Shared constants, loader state encoding and table-walk helpers for the PMA region loader.
package rfPhoenixMmupkg;

    localparam logic [31:0] PMA_UNLK   = 32'h554E_4C4B;
    localparam logic [31:0] PMA_LOCK   = 32'h4C4F_434B;
    localparam logic [3:0]  PMA_W_LOCK = 4'd14;
    localparam logic [3:0]  PMA_W_LAST = 4'd8;
    // Step 0 is the unlock write, steps 1..9 are words 0..8, step 10 is the image lock word.
    localparam logic [3:0]  STEP_LAST  = 4'd10;

    typedef enum logic [2:0] {
        StIdle,
        StUnlock,
        StFetch,
        StWrite,
        StRdbk,
        StCmp,
        StNext,
        StFin
    } ldr_state_e;

    function automatic logic [3:0] step_word(input logic [3:0] step);
        if (step == 4'd0 || step == STEP_LAST) begin
            return PMA_W_LOCK;
        end
        return step - 4'd1;
    endfunction

    function automatic logic [31:0] cmp_mask(input logic [3:0] word);
        case (word)
            4'd1, 4'd3, 4'd5, 4'd7: return 32'h0000_FFFF;
            PMA_W_LAST:             return 32'h000F_FFFF;
            default:                return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/rfphoenix_pma_loader_tmo_counter.sv
// Memory-ack watchdog: cleared by load, advanced by count, expire flags the TMO-th waiting cycle.
module rfphoenix_pma_tmo_counter #(
    parameter int unsigned TMO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int unsigned W = $clog2(TMO + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == W'(TMO - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rfphoenix_pma_loader.sv
// Walks a memory image table and programs NREG PMA regions (unlock, words 0..8, lock).
// Define RFPHOENIX_PMA_LOADER_VERIFY_EN to read back and compare every register write.
module rfphoenix_pma_loader #(
    parameter int unsigned NREG = 8,
    parameter int unsigned TMO  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_adr,
    output logic        m_req,
    output logic [31:0] m_adr,
    input  logic        m_ack,
    input  logic [31:0] m_dat,
    output logic        rg_wr,
    output logic [6:0]  rg_rwa,
    output logic [31:0] rg_dat,
    input  logic [31:0] rg_rdat,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_region
);

    import rfPhoenixMmupkg::*;

    ldr_state_e  state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [2:0]  region_q, region_d;
    logic [31:0] base_q, base_d;
    logic        m_req_q, m_req_d;
    logic [31:0] m_adr_q, m_adr_d;
    logic        rg_wr_q, rg_wr_d;
    logic [6:0]  rg_rwa_q, rg_rwa_d;
    logic [31:0] rg_dat_q, rg_dat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [2:0]  err_region_q, err_region_d;
    logic        advance;
    logic        mismatch;
    logic        tmo_expire;

    rfphoenix_pma_tmo_counter #(
        .TMO (TMO)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   ((state_d == StFetch) && (state_q != StFetch)),
        .count  (state_q == StFetch),
        .expire (tmo_expire)
    );

    // rg_dat_q still holds the value just written while the readback is compared.
    assign mismatch = |((rg_rdat ^ rg_dat_q) & cmp_mask(rg_rwa_q[3:0]));

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        region_d     = region_q;
        base_d       = base_q;
        m_adr_d      = m_adr_q;
        rg_rwa_d     = rg_rwa_q;
        rg_dat_d     = rg_dat_q;
        err_d        = err_q;
        err_region_d = err_region_q;
        advance      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d       = base_adr;
                    region_d     = 3'd0;
                    step_d       = 4'd0;
                    err_d        = 1'b0;
                    err_region_d = 3'd0;
                    rg_rwa_d     = {3'd0, PMA_W_LOCK};
                    rg_dat_d     = PMA_UNLK;
                    state_d      = StUnlock;
                end
            end
            StUnlock, StWrite: begin
`ifdef RFPHOENIX_PMA_LOADER_VERIFY_EN
                state_d = StRdbk;
`else
                advance = 1'b1;
`endif
            end
            StFetch: begin
                if (m_ack) begin
                    rg_dat_d = m_dat;
                    rg_rwa_d = {region_q, step_word(step_q)};
                    state_d  = StWrite;
                end else if (tmo_expire) begin
                    err_d        = 1'b1;
                    err_region_d = region_q;
                    state_d      = StFin;
                end
            end
            StRdbk: begin
                state_d = StCmp;
            end
            StCmp: begin
                if (mismatch) begin
                    err_d        = 1'b1;
                    err_region_d = region_q;
                    state_d      = StFin;
                end else begin
                    advance = 1'b1;
                end
            end
            StNext: begin
                if (region_q == 3'(NREG - 1)) begin
                    state_d = StFin;
                end else begin
                    region_d = region_q + 3'd1;
                    step_d   = 4'd0;
                    rg_rwa_d = {region_d, PMA_W_LOCK};
                    rg_dat_d = PMA_UNLK;
                    state_d  = StUnlock;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
        endcase

        if (advance) begin
            if (step_q == STEP_LAST) begin
                state_d = StNext;
            end else begin
                step_d  = step_q + 4'd1;
                m_adr_d = base_q + {23'd0, region_q, 6'd0} + {26'd0, step_word(step_d), 2'd0};
                state_d = StFetch;
            end
        end

        // All handshake outputs are registered copies of the upcoming state.
        m_req_d = (state_d == StFetch);
        rg_wr_d = (state_d == StUnlock) || (state_d == StWrite);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StFin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            step_q       <= '0;
            region_q     <= '0;
            base_q       <= '0;
            m_req_q      <= 1'b0;
            m_adr_q      <= '0;
            rg_wr_q      <= 1'b0;
            rg_rwa_q     <= '0;
            rg_dat_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_region_q <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            region_q     <= region_d;
            base_q       <= base_d;
            m_req_q      <= m_req_d;
            m_adr_q      <= m_adr_d;
            rg_wr_q      <= rg_wr_d;
            rg_rwa_q     <= rg_rwa_d;
            rg_dat_q     <= rg_dat_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_region_q <= err_region_d;
        end
    end

    assign m_req      = m_req_q;
    assign m_adr      = m_adr_q;
    assign rg_wr      = rg_wr_q;
    assign rg_rwa     = rg_rwa_q;
    assign rg_dat     = rg_dat_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_region = err_region_q;

endmodule

// File: tb/tb_rfphoenix_pma_loader.sv
// Self-checking bench for rfphoenix_pma_loader: random-latency memory, PMA register model,
// and a table-walk reference list of expected register writes.
module tb_rfphoenix_pma_loader;

    localparam int NREG = 8;
    localparam int TMO  = 255;
    localparam logic [31:0] UNLK = 32'h554E_4C4B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_adr = '0;
    logic        m_req;
    logic [31:0] m_adr;
    logic        m_ack;
    logic [31:0] m_dat;
    logic        rg_wr;
    logic [6:0]  rg_rwa;
    logic [31:0] rg_dat;
    logic [31:0] rg_rdat;
    logic        busy, done, err;
    logic [2:0]  err_region;

    rfphoenix_pma_loader #(
        .NREG (NREG),
        .TMO  (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_adr   (base_adr),
        .m_req      (m_req),
        .m_adr      (m_adr),
        .m_ack      (m_ack),
        .m_dat      (m_dat),
        .rg_wr      (rg_wr),
        .rg_rwa     (rg_rwa),
        .rg_dat     (rg_dat),
        .rg_rdat    (rg_rdat),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_region (err_region)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [31:0] seed;
    int max_lat = 3, lat = 0;
    logic inject = 1'b0;
    logic stall_en = 1'b0;
    logic [31:0] stall_adr = '0;
    logic corr_all = 1'b0;
    logic [2:0] corr_region = '0;
    logic [3:0] corr_word = '0;
    logic [31:0] corr_mask = '0;
    logic [31:0] pma [128];
    logic [38:0] wr_q [$];
    logic [38:0] exp_q [$];
    int cyc = 0, last_wr_t = 0, done_t = 0, done_cnt = 0, viol = 0;
    int req_run = 0, req_run_max = 0;
    logic prev_req = 1'b0;
    logic [31:0] prev_adr = '0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // PMA register file: rg_rdat returns the addressed word one cycle later.
    always @(posedge clk) begin
        if (rg_wr) pma[rg_rwa] <= rg_dat;
        rg_rdat <= pma[rg_rwa] ^ (((rg_rwa[3:0] == corr_word) &&
                   (corr_all || rg_rwa[6:4] == corr_region)) ? corr_mask : 32'h0);
    end

    // Memory responder: random ack latency, optional stall on one address.
    initial begin
        m_ack = 1'b0;
        m_dat = '0;
        forever begin
            @(negedge clk);
            #2;
            if (inject) begin
                m_ack = 1'b1;
                m_dat = $urandom;
            end else if (m_ack || !m_req) begin
                m_ack = 1'b0;
                m_dat = $urandom;
                lat = $urandom_range(max_lat, 0);
            end else if (stall_en && m_adr == stall_adr) begin
                m_ack = 1'b0;
            end else if (lat == 0) begin
                m_ack = 1'b1;
                m_dat = img(m_adr);
            end else begin
                lat--;
            end
        end
    end

    // Monitor: logs writes, done pulses and protocol violations.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rg_wr) begin
            wr_q.push_back({rg_rwa, rg_dat});
            last_wr_t = cyc;
        end
        if (done) begin
            done_cnt++;
            done_t = cyc;
            if (!busy) viol++;
        end
        if (m_req) begin
            req_run++;
            if (req_run > req_run_max) req_run_max = req_run;
            if (prev_req && m_adr != prev_adr) viol++;
        end else begin
            req_run = 0;
        end
        prev_req = m_req;
        prev_adr = m_adr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0: full load; 1: timeout on (ar,ak), write not issued; 2: compare fails after (ar,ak)
    task automatic build_exp(input logic [31:0] b, input int kind, input int ar, input int ak);
        int ks [11];
        logic [31:0] d;
        ks = '{14, 0, 1, 2, 3, 4, 5, 6, 7, 8, 14};
        exp_q.delete();
        for (int r = 0; r < NREG; r++) begin
            for (int s = 0; s < 11; s++) begin
                if (kind == 1 && r == ar && s != 0 && ks[s] == ak) return;
                d = (s == 0) ? UNLK : img(b + 32'(r * 64 + ks[s] * 4));
                exp_q.push_back({3'(r), 4'(ks[s]), d});
                if (kind == 2 && r == ar && s != 0 && ks[s] == ak) return;
            end
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        done_cnt = 0;
        viol = 0;
        req_run_max = 0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic with_ack);
        @(negedge clk);
        #1;
        base_adr = b;
        start = 1'b1;
        inject = with_ack;
        @(negedge clk);
        #1;
        start = 1'b0;
        inject = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt > 0), 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic finish_run(input string tag, input logic e_err, input logic [2:0] e_reg);
        int n;
        chk({tag, "_done_once"}, 64'(done_cnt), 1);
        chk({tag, "_err"}, 64'(err), 64'(e_err));
        chk({tag, "_err_region"}, 64'(err_region), 64'(e_reg));
        chk({tag, "_busy_idle"}, 64'(busy), 0);
        chk({tag, "_protocol"}, 64'(viol), 0);
        chk({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
        if (wr_q.size() > 0) chk({tag, "_done_after_wr"}, 64'(done_t > last_wr_t), 1);
    endtask

    initial begin
        logic [31:0] b;
        int n;
        seed = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 64'({busy, done, err, m_req, rg_wr}), 0);
        chk("rst_err_region", 64'(err_region), 0);
        chk("rst_rg_rwa", 64'(rg_rwa), 0);
        chk("rst_m_adr", 64'(m_adr), 0);
        chk("rst_rg_dat", 64'(rg_dat), 0);
        rst_n = 1'b1;

        // Full load; a second start mid-load must be ignored.
        b = $urandom & 32'hFFFF_FFFC;
        clear_log();
        build_exp(b, 0, 0, 0);
        do_start(b, 1'b1);
        chk("full_busy_after_start", 64'(busy), 1);
        repeat (7) @(negedge clk);
        do_start(b ^ 32'h0001_0000, 1'b0);
        wait_done("full");
        finish_run("full", 1'b0, 3'd0);

        // Memory never acks region 2 word 3.
        b = $urandom & 32'hFFFF_FFFC;
        stall_en = 1'b1;
        stall_adr = b + 32'd140;
        clear_log();
        build_exp(b, 1, 2, 3);
        do_start(b, 1'b1);
        wait_done("tmo");
        finish_run("tmo", 1'b1, 3'd2);
        chk("tmo_req_cycles", 64'(req_run_max), 64'(TMO));
        stall_en = 1'b0;

        // Readback of region 1 word 4 returns bit 0 flipped.
        b = $urandom & 32'hFFFF_FFFC;
        corr_region = 3'd1;
        corr_word = 4'd4;
        corr_mask = 32'h1;
        clear_log();
`ifdef RFPHOENIX_PMA_LOADER_VERIFY_EN
        build_exp(b, 2, 1, 4);
`else
        build_exp(b, 0, 0, 0);
`endif
        do_start(b, 1'b1);
        chk("mis_err_cleared", 64'({err, err_region}), 0);
        wait_done("mis");
`ifdef RFPHOENIX_PMA_LOADER_VERIFY_EN
        finish_run("mis", 1'b1, 3'd1);
`else
        finish_run("mis", 1'b0, 3'd0);
`endif

        // Upper half of word 3 differs on readback; only [15:0] are compared.
        b = $urandom & 32'hFFFF_FFFC;
        corr_all = 1'b1;
        corr_word = 4'd3;
        corr_mask = 32'hABCD_0000;
        clear_log();
        build_exp(b, 0, 0, 0);
        do_start(b, 1'b1);
        chk("hi_err_cleared", 64'({err, err_region}), 0);
        wait_done("hi");
        finish_run("hi", 1'b0, 3'd0);
        corr_all = 1'b0;
        corr_mask = 32'h0;

        // Reset while region 3 word 2 is being written.
        b = $urandom & 32'hFFFF_FFFC;
        clear_log();
        do_start(b, 1'b1);
        n = 0;
        while (!(rg_wr && rg_rwa == 7'h32) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_reached", 64'(rg_wr && rg_rwa == 7'h32), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_outs", 64'({rg_wr, busy, m_req, done}), 0);
        chk("rstmid_unlk_kept", 64'(pma[7'h3E]), 64'(UNLK));
        clear_log();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid_no_writes", 64'(wr_q.size()), 0);
        chk("rstmid_idle", 64'(busy), 0);
        clear_log();
        build_exp(b, 0, 0, 0);
        do_start(b, 1'b1);
        wait_done("reload");
        finish_run("reload", 1'b0, 3'd0);

        // Random bases and latencies, fast and slow memory.
        for (int t = 0; t < 3; t++) begin
            max_lat = (t == 0) ? 0 : 6;
            seed = $urandom;
            b = $urandom & 32'hFFFF_FFFC;
            clear_log();
            build_exp(b, 0, 0, 0);
            do_start(b, 1'b1);
            wait_done($sformatf("rnd%0d", t));
            finish_run($sformatf("rnd%0d", t), 1'b0, 3'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
